// File: rtl/adc_scan_ctrl_if.sv
// adc_scan_ctrl_if -- serial link between the scan controller and the ADC.
//   adc_cs_n : chip select, active low (controller -> ADC)
//   adc_sclk : serial clock, idles high (controller -> ADC)
//   adc_din  : serial channel address (controller -> ADC)
//   adc_dout : serial conversion data (ADC -> controller)
// modport master: controller side; modport slave: ADC side.
interface adc_scan_ctrl_if;
    logic adc_cs_n;
    logic adc_sclk;
    logic adc_din;
    logic adc_dout;

    modport master (output adc_cs_n, output adc_sclk, output adc_din, input adc_dout);
    modport slave  (input adc_cs_n, input adc_sclk, input adc_din, output adc_dout);
endinterface

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl -- scans NUM_CH ADC channels over a 16-clock serial frame.
// A scan is NUM_CH+1 frames: each frame addresses the next channel and
// returns the conversion of the channel addressed in the previous frame,
// so frame 0's data is thrown away and the last frame re-addresses ch 0.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   start           one-cycle request for a single scan (ignored while busy)
//   cont_en         keep scanning back-to-back while high
//   adc             serial ADC link (adc_scan_ctrl_if.master)
//   data_out/ch_out latest conversion and its channel
//   data_valid      one-cycle strobe when data_out/ch_out update
//   res_bus         per-channel result buffer, channel c at [c*RES +: RES]
//   scan_done       one-cycle strobe with the last channel's data_valid
//   busy            high whenever the FSM is not IDLE
//   line_bits       per-channel result >= THRESH flags
//
// Build option: define ADC_LSA_THRESH_EN to build the threshold comparators;
// otherwise line_bits is tied to zero.
//
// state | meaning
// IDLE  | link idle, cs_n high, waiting for start / cont_en
// SETUP | cs_n low, sclk high for CLK_DIV cycles before the first fall
// SHIFT | 16 sclk periods, address out on falls, data in on rises
// GAP   | cs_n high for CLK_DIV cycles between frames
module adc_scan_ctrl #(
    parameter int          NUM_CH  = 4,
    parameter int          RES     = 12,
    parameter int          CLK_DIV = 1,
    parameter logic [11:0] THRESH  = 12'h800
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cont_en,
    adc_scan_ctrl_if.master       adc,
    output logic [RES-1:0]        data_out,
    output logic [2:0]            ch_out,
    output logic                  data_valid,
    output logic [NUM_CH*RES-1:0] res_bus,
    output logic                  scan_done,
    output logic                  busy,
    output logic [NUM_CH-1:0]     line_bits
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [3:0] LAST_FRAME = 4'(NUM_CH);

    state_t     state;
    logic [7:0] div_cnt;
    logic [3:0] bit_idx;
    logic [3:0] frame;
    logic [11:0] shreg;
    logic       cap_pend;
    logic       done_pend;
    logic [2:0] cap_ch;
    logic       cs_n_q;
    logic       sclk_q;
    logic       din_q;
    logic [2:0] frame_addr;
    logic [RES-1:0] result;

    assign adc.adc_cs_n = cs_n_q;
    assign adc.adc_sclk = sclk_q;
    assign adc.adc_din  = din_q;

    // After 16 samples bit i sits at position 15-i, so bits i=4.. start at 11.
    assign result     = shreg[11 -: RES];
    assign frame_addr = (frame == LAST_FRAME) ? 3'd0 : frame[2:0];

    function automatic logic din_bit(input logic [3:0] idx, input logic [2:0] addr);
        case (idx)
            4'd2:    return addr[2];
            4'd3:    return addr[1];
            4'd4:    return addr[0];
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_idx    <= '0;
            frame      <= '0;
            shreg      <= '0;
            cap_pend   <= 1'b0;
            done_pend  <= 1'b0;
            cap_ch     <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b1;
            din_q      <= 1'b0;
            data_out   <= '0;
            ch_out     <= '0;
            data_valid <= 1'b0;
            scan_done  <= 1'b0;
            busy       <= 1'b0;
            res_bus    <= '0;
        end else begin
            data_valid <= 1'b0;
            scan_done  <= 1'b0;
            cap_pend   <= 1'b0;
            done_pend  <= 1'b0;

            // Publish one clk after the 16th rising edge, once the last bit is in.
            if (cap_pend) begin
                data_out   <= result;
                ch_out     <= cap_ch;
                data_valid <= 1'b1;
                scan_done  <= done_pend;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (cap_ch == 3'(c)) res_bus[c*RES +: RES] <= result;
                end
            end

            case (state)
                IDLE: begin
                    if (start || cont_en) begin
                        state   <= SETUP;
                        busy    <= 1'b1;
                        cs_n_q  <= 1'b0;
                        sclk_q  <= 1'b1;
                        frame   <= '0;
                        div_cnt <= DIV_RELOAD;
                    end
                end
                SETUP: begin
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        state   <= SHIFT;
                        sclk_q  <= 1'b0;
                        bit_idx <= '0;
                        din_q   <= din_bit(4'd0, frame_addr);
                        div_cnt <= DIV_RELOAD;
                    end
                end
                SHIFT: begin
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else if (!sclk_q) begin
                        sclk_q  <= 1'b1;
                        shreg   <= {shreg[10:0], adc.adc_dout};
                        div_cnt <= DIV_RELOAD;
                        if (bit_idx == 4'd15 && frame != 4'd0) begin
                            cap_pend  <= 1'b1;
                            done_pend <= (frame == LAST_FRAME);
                            cap_ch    <= 3'(frame - 4'd1);
                        end
                    end else if (bit_idx == 4'd15) begin
                        state   <= GAP;
                        cs_n_q  <= 1'b1;
                        din_q   <= 1'b0;
                        div_cnt <= DIV_RELOAD;
                    end else begin
                        sclk_q  <= 1'b0;
                        bit_idx <= bit_idx + 4'd1;
                        din_q   <= din_bit(bit_idx + 4'd1, frame_addr);
                        div_cnt <= DIV_RELOAD;
                    end
                end
                GAP: begin
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else if (frame != LAST_FRAME) begin
                        state   <= SETUP;
                        frame   <= frame + 4'd1;
                        cs_n_q  <= 1'b0;
                        div_cnt <= DIV_RELOAD;
                    end else if (cont_en) begin
                        state   <= SETUP;
                        frame   <= '0;
                        cs_n_q  <= 1'b0;
                        div_cnt <= DIV_RELOAD;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADC_LSA_THRESH_EN
    localparam logic [RES-1:0] THR_CMP = THRESH[11 -: RES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_bits <= '0;
        end else if (cap_pend) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cap_ch == 3'(c)) line_bits[c] <= (result >= THR_CMP);
            end
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
    assign line_bits     = '0;
`endif

endmodule

// File: tb/tb_adc_scan_ctrl.sv
module tb_adc_scan_ctrl;
    localparam int NCH = 4;
    localparam int RES = 12;
`ifdef ADC_LSA_THRESH_EN
    localparam bit LINE_ON = 1'b1;
`else
    localparam bit LINE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, cont0 = 1'b0, start1 = 1'b0, cont1 = 1'b0;
    always #5 clk = ~clk;

    adc_scan_ctrl_if if0 ();
    adc_scan_ctrl_if if1 ();

    logic [RES-1:0]     data_out0, data_out1;
    logic [2:0]         ch_out0, ch_out1;
    logic               dv0, dv1, done0, done1, busy0, busy1;
    logic [NCH*RES-1:0] res_bus0, res_bus1;
    logic [NCH-1:0]     line0, line1;

    adc_scan_ctrl #(.NUM_CH(NCH), .RES(RES), .CLK_DIV(1), .THRESH(12'h800)) u0 (
        .clk(clk), .rst(rst), .start(start0), .cont_en(cont0), .adc(if0),
        .data_out(data_out0), .ch_out(ch_out0), .data_valid(dv0), .res_bus(res_bus0),
        .scan_done(done0), .busy(busy0), .line_bits(line0));

    adc_scan_ctrl #(.NUM_CH(NCH), .RES(RES), .CLK_DIV(3), .THRESH(12'h800)) u1 (
        .clk(clk), .rst(rst), .start(start1), .cont_en(cont1), .adc(if1),
        .data_out(data_out1), .ch_out(ch_out1), .data_valid(dv1), .res_bus(res_bus1),
        .scan_done(done1), .busy(busy1), .line_bits(line1));

    int tests = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ADC model for u0: returns the channel addressed in the previous frame,
    // MSB-first on bits i=4..15, changing on sclk falls.
    logic [11:0] ch_val [8];
    int          fall_cnt = 0;
    int          win_cnt = 0;
    logic [2:0]  dec_addr = 3'd0;
    logic [2:0]  cur_ch = 3'd0;
    int          addr_q[$];
    int          falls_q[$];

    always @(negedge if0.adc_cs_n) begin
        fall_cnt = 0;
        win_cnt++;
    end
    always @(negedge if0.adc_sclk) begin
        if (if0.adc_cs_n === 1'b0) begin
            if (fall_cnt >= 4 && fall_cnt <= 15) if0.adc_dout = ch_val[cur_ch][15 - fall_cnt];
            else if0.adc_dout = 1'b0;
            fall_cnt++;
        end
    end
    always @(posedge if0.adc_sclk) begin
        if (if0.adc_cs_n === 1'b0 && fall_cnt >= 3 && fall_cnt <= 5)
            dec_addr[5 - fall_cnt] = if0.adc_din;
    end
    always @(posedge if0.adc_cs_n) begin
        addr_q.push_back(int'(dec_addr));
        falls_q.push_back(fall_cnt);
        cur_ch = dec_addr;
    end

    assign if1.adc_dout = 1'b1;

    // Scoreboard for u0 data_valid strobes.
    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] data;
        logic        done;
    } sb_t;
    sb_t sb_q[$];
    sb_t sb_e;

    task automatic push_scan(input logic [3:0][11:0] v);
        for (int c = 0; c < NCH; c++) begin
            sb_e.ch   = 3'(c);
            sb_e.data = v[c];
            sb_e.done = (c == NCH - 1);
            sb_q.push_back(sb_e);
        end
    endtask

    int busy_cnt0 = 0, done_cnt0 = 0, gap_run = 0;
    int gap_q[$];

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (busy0) busy_cnt0++;
            if (done0) done_cnt0++;
            if (!busy0) gap_run = 0;
            else if (if0.adc_cs_n) gap_run++;
            else if (gap_run > 0) begin
                gap_q.push_back(gap_run);
                gap_run = 0;
            end
            if (dv0 || done0) begin
                if (sb_q.size() == 0) chk("spurious_strobe", 64'({dv0, done0}), 64'd0);
                else begin
                    sb_e = sb_q.pop_front();
                    chk("data_valid", 64'(dv0), 64'd1);
                    chk("ch_out", 64'(ch_out0), 64'(sb_e.ch));
                    chk("data_out", 64'(data_out0), 64'(sb_e.data));
                    chk("scan_done", 64'(done0), 64'(sb_e.done));
                end
            end
        end
    end

    // u1 timing monitors.
    int busy_cnt1 = 0, dv_cnt1 = 0, done_cnt1 = 0, cyc = 0, last_fall = -1;
    int lo_run1 = 0, hi_run1 = 0, runs_seen1 = 0, runs_bad1 = 0;
    int period_q[$];
    logic prev_cs1 = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (busy1) busy_cnt1++;
        if (dv1) dv_cnt1++;
        if (done1) done_cnt1++;
        if (if1.adc_cs_n === 1'b0) begin
            if (if1.adc_sclk) begin
                if (lo_run1 > 0) begin
                    runs_seen1++;
                    if (lo_run1 != 3) runs_bad1++;
                    lo_run1 = 0;
                end
                hi_run1++;
            end else begin
                if (hi_run1 > 0) begin
                    runs_seen1++;
                    if (hi_run1 != 3) runs_bad1++;
                    hi_run1 = 0;
                end
                lo_run1++;
            end
        end else begin
            if (hi_run1 > 0) begin
                runs_seen1++;
                if (hi_run1 != 3) runs_bad1++;
            end
            hi_run1 = 0;
            lo_run1 = 0;
        end
        if (prev_cs1 === 1'b1 && if1.adc_cs_n === 1'b0) begin
            if (last_fall >= 0) period_q.push_back(cyc - last_fall);
            last_fall = cyc;
        end
        prev_cs1 = if1.adc_cs_n;
    end

    task automatic pulse_start(input bit which);
        @(negedge clk);
        if (which) start1 = 1'b1;
        else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_idle(input bit which, input int max_cyc, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((which ? busy1 : busy0) && n < max_cyc);
        chk({name, "_idle"}, 64'(which ? busy1 : busy0), 64'd0);
    endtask

    task automatic clear_u0;
        addr_q.delete();
        falls_q.delete();
        gap_q.delete();
        sb_q.delete();
        busy_cnt0 = 0;
        done_cnt0 = 0;
    endtask

    task automatic check_frames(input string name);
        chk({name, "_frames"}, 64'(addr_q.size()), 64'd5);
        for (int f = 0; f < addr_q.size() && f < 5; f++) begin
            chk({name, "_addr"}, 64'(addr_q[f]), 64'((f < NCH) ? f : 0));
            chk({name, "_falls"}, 64'(falls_q[f]), 64'd16);
        end
        chk({name, "_gaps"}, 64'(gap_q.size()), 64'd4);
        for (int g = 0; g < gap_q.size() && g < 4; g++)
            chk({name, "_gap_len"}, 64'(gap_q[g]), 64'd1);
    endtask

    typedef struct packed {
        logic [3:0][11:0] v;
        logic [3:0]       exp_line;
    } vec_t;
    vec_t vecs [3];

    initial begin : main
        int n;
        int w0;
        logic [3:0] exp_l;

        vecs[0].v = {12'h27A, 12'h5AC, 12'h674, 12'hB96};
        vecs[0].exp_line = 4'b0001;
        vecs[1].v = {12'h7FF, 12'h800, 12'hFFF, 12'h000};
        vecs[1].exp_line = 4'b0110;
        vecs[2].v = {12'h000, 12'h800, 12'h001, 12'hFFF};
        vecs[2].exp_line = 4'b0101;
        for (int c = 0; c < 8; c++) ch_val[c] = 12'h000;

        repeat (3) @(negedge clk);
        chk("rst_cs_n", 64'(if0.adc_cs_n), 64'd1);
        chk("rst_sclk", 64'(if0.adc_sclk), 64'd1);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_res_bus", 64'(res_bus0), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", 64'(busy0), 64'd0);

        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < NCH; c++) ch_val[c] = vecs[i].v[c];
            clear_u0();
            push_scan(vecs[i].v);
            pulse_start(1'b0);
            wait_idle(1'b0, 400, "scan");
            chk("scan_cycles", 64'(busy_cnt0), 64'd170);
            chk("scan_done_cnt", 64'(done_cnt0), 64'd1);
            chk("res_bus", 64'(res_bus0), 64'(vecs[i].v));
            exp_l = LINE_ON ? vecs[i].exp_line : 4'b0000;
            chk("line_bits", 64'(line0), 64'(exp_l));
            chk("sb_drained", 64'(sb_q.size()), 64'd0);
            check_frames("scan");
        end

        // Continuous mode: clear cont_en during the second scan.
        for (int c = 0; c < NCH; c++) ch_val[c] = vecs[0].v[c];
        clear_u0();
        push_scan(vecs[0].v);
        push_scan(vecs[0].v);
        w0 = win_cnt;
        @(negedge clk);
        cont0 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done_cnt0 < 1 && n < 400);
        chk("cont_first_done", 64'(done_cnt0), 64'd1);
        repeat (50) @(negedge clk);
        cont0 = 1'b0;
        wait_idle(1'b0, 400, "cont");
        chk("cont_done_cnt", 64'(done_cnt0), 64'd2);
        chk("cont_cycles", 64'(busy_cnt0), 64'd340);
        chk("cont_sb_drained", 64'(sb_q.size()), 64'd0);
        repeat (40) @(negedge clk);
        chk("cont_stays_idle", 64'(busy0), 64'd0);
        chk("cont_windows", 64'(win_cnt - w0), 64'd10);

        // Reset at bit 8 of frame 2.
        clear_u0();
        push_scan(vecs[0].v);
        w0 = win_cnt;
        pulse_start(1'b0);
        n = 0;
        while (!((win_cnt - w0) == 3 && fall_cnt == 9) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rst_point_reached", 64'((win_cnt - w0) == 3 && fall_cnt == 9), 64'd1);
        chk("pre_rst_data", 64'(data_out0), 64'h B96);
        rst = 1'b1;
        #1;
        chk("mid_rst_cs_n", 64'(if0.adc_cs_n), 64'd1);
        chk("mid_rst_sclk", 64'(if0.adc_sclk), 64'd1);
        chk("mid_rst_din", 64'(if0.adc_din), 64'd0);
        chk("mid_rst_data", 64'(data_out0), 64'd0);
        chk("mid_rst_ch", 64'(ch_out0), 64'd0);
        chk("mid_rst_flags", 64'({dv0, done0, busy0}), 64'd0);
        chk("mid_rst_res_bus", 64'(res_bus0), 64'd0);
        chk("mid_rst_line", 64'(line0), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_u0();
        push_scan(vecs[0].v);
        pulse_start(1'b0);
        wait_idle(1'b0, 400, "post_rst");
        chk("post_rst_cycles", 64'(busy_cnt0), 64'd170);
        chk("post_rst_res_bus", 64'(res_bus0), 64'(vecs[0].v));
        chk("post_rst_done", 64'(done_cnt0), 64'd1);
        chk("post_rst_sb", 64'(sb_q.size()), 64'd0);
        check_frames("post_rst");

        // CLK_DIV=3 instance, second start while busy.
        busy_cnt1 = 0; dv_cnt1 = 0; done_cnt1 = 0; runs_seen1 = 0; runs_bad1 = 0;
        period_q.delete();
        last_fall = -1;
        pulse_start(1'b1);
        repeat (40) @(negedge clk);
        pulse_start(1'b1);
        wait_idle(1'b1, 1200, "div3");
        chk("div3_cycles", 64'(busy_cnt1), 64'd510);
        chk("div3_done_cnt", 64'(done_cnt1), 64'd1);
        chk("div3_valid_cnt", 64'(dv_cnt1), 64'd4);
        chk("div3_data", 64'(data_out1), 64'h FFF);
        chk("div3_ch", 64'(ch_out1), 64'd3);
        chk("div3_runs", 64'(runs_seen1), 64'd165);
        chk("div3_bad_runs", 64'(runs_bad1), 64'd0);
        chk("div3_periods", 64'(period_q.size()), 64'd4);
        for (int p = 0; p < period_q.size() && p < 4; p++)
            chk("div3_frame_len", 64'(period_q[p]), 64'd102);
        repeat (20) @(negedge clk);
        chk("div3_single_scan", 64'(busy1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin : watchdog
        #200000;
        failed++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of channels scanned (1..8, addresses 0..NUM_CH-1).
REQ-002 SHALL have parameter RES, default 12, result width (8, 10 or 12).
REQ-003 SHALL have parameter CLK_DIV, default 1, clk cycles per SCLK half-period (1..255).
REQ-004 SHALL have parameter THRESH, default 12'h800, line-detect threshold (used only under REQ-034).
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  single-cycle request for one scan.
REQ-008 SHALL have port cont_en  input  1  continuous scanning while high.
REQ-009 SHALL have port adc_dout  input  1  serial data from ADC.
REQ-010 SHALL have port adc_cs_n  output  1  ADC chip select, active low.
REQ-011 SHALL have port adc_sclk  output  1  ADC serial clock; idles high.
REQ-012 SHALL have port adc_din  output  1  serial channel address to ADC.
REQ-013 SHALL have port data_out  output  RES  most recent conversion result.
REQ-014 SHALL have port ch_out  output  3  channel of data_out.
REQ-015 SHALL have port data_valid  output  1  one-cycle strobe when data_out/ch_out update.
REQ-016 SHALL have port res_bus  output  NUM_CH*RES  per-channel result buffer; channel c at [c*RES +: RES].
REQ-017 SHALL have port scan_done  output  1  one-cycle strobe at end of scan.
REQ-018 SHALL have port busy  output  1  high while not IDLE.
REQ-019 SHALL have port line_bits  output  NUM_CH  per-channel threshold flags.

Function
REQ-020 FSM states SHALL be IDLE, SETUP, SHIFT, GAP; IDLE -> SETUP on start or cont_en.
REQ-021 SETUP: adc_cs_n=0, adc_sclk=1 for CLK_DIV cycles -> SHIFT.
REQ-022 SHIFT: exactly 16 SCLK periods, each low CLK_DIV cycles then high CLK_DIV cycles, bit index i=0..15.
REQ-023 adc_din SHALL change only at SCLK falling edges: addr[2] at i=2, addr[1] at i=3, addr[0] at i=4, 0 otherwise.
REQ-024 adc_dout SHALL be sampled at each SCLK rising edge; bits i=4..3+RES form the result, MSB first.
REQ-025 After the 16th rising edge: SHIFT -> GAP; GAP holds adc_cs_n=1, adc_sclk=1 for CLK_DIV cycles.
REQ-026 Scan SHALL be NUM_CH+1 frames: frame k (0..NUM_CH-1) addresses channel k; frame NUM_CH addresses channel 0.
REQ-027 Frame 0 result SHALL be discarded; frame k>=1 result belongs to channel k-1.
REQ-028 For frames k>=1, one clk after the 16th rising edge: data_out=result, ch_out=k-1, res_bus slot k-1 written, data_valid=1 for one cycle.
REQ-029 scan_done SHALL pulse coincident with the channel NUM_CH-1 data_valid.
REQ-030 GAP after last frame -> SETUP (new scan) if cont_en=1, else IDLE.
REQ-031 start while busy SHALL be ignored; cont_en deassertion mid-scan SHALL complete the current scan first.
REQ-032 Frame duration SHALL be 34*CLK_DIV clk cycles; scan = (NUM_CH+1)*34*CLK_DIV cycles.

Reset
REQ-033 rst SHALL immediately force IDLE, adc_cs_n=1, adc_sclk=1, adc_din=0, data_out=0, ch_out=0, data_valid=0, scan_done=0, busy=0, res_bus=0, line_bits=0, all counters 0; mid-frame data discarded.

Configuration
REQ-034 With ADC_LSA_THRESH_EN defined, line_bits[c] SHALL update with channel c's capture to (result >= THRESH[11:12-RES]); without it line_bits SHALL be constant 0 and no comparator logic exists.

Verification
REQ-035 NUM_CH=4, CLK_DIV=1, start pulse, ADC model returns ch0..3 = 12'hB96,12'h674,12'h5AC,12'h27A -> four data_valid with ch_out 0..3 and these values, scan_done with last, busy low after 170 cycles.
REQ-036 Same run: adc_din frame addresses decode 0,1,2,3,0; adc_sclk exactly 16 falls per cs_n-low window; adc_cs_n high 1 cycle between frames.
REQ-037 cont_en=1 for two scans, cleared during scan 2 -> scan 2 completes (second scan_done), then IDLE, no third SETUP.
REQ-038 rst asserted at bit i=8 of frame 2 -> outputs at REQ-033 values same cycle; subsequent start yields full correct scan.
REQ-039 ADC_LSA_THRESH_EN, THRESH=12'h800, above data -> line_bits=4'b0001 after scan; without macro line_bits=0.
REQ-040 CLK_DIV=3, start asserted while busy -> SCLK half-period 3 cycles, frame 102 cycles, single scan only.
